// File: rtl/packet_unpack_pkg.sv
// packet_unpack_pkg: shared constants, flag state type and bits_in clamp for packet_unpack.
// Default geometry is 32-bit words to 7-bit symbols; CNT_W/BUF_W size the residue for that geometry.
package packet_unpack_pkg;
    localparam int IN_WIDTH_DEF  = 32;
    localparam int OUT_WIDTH_DEF = 7;
    localparam int CNT_W         = $clog2(IN_WIDTH_DEF + OUT_WIDTH_DEF);
    localparam int BUF_W         = IN_WIDTH_DEF + OUT_WIDTH_DEF - 1;

    typedef struct packed {
        logic in_pkt;
        logic sop_pend;
        logic eop_pend;
    } flags_t;

    // Valid bits carried by a word: full width unless an EOP word names a count in 1..width.
    function automatic int valid_bits(input logic eop, input int bits, input int width);
        return (!eop || bits == 0 || bits > width) ? width : bits;
    endfunction
endpackage

// File: rtl/packet_unpack_if.sv
// packet_unpack_if: word ingress and symbol egress signals of packet_unpack.
// slave is the unpacker side, master is the side that feeds words and accepts symbols.
interface packet_unpack_if import packet_unpack_pkg::*; #(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int BITS_W    = $clog2(IN_WIDTH + 1)
);
    logic                 valid_in, ready_out, sop_in, eop_in;
    logic [IN_WIDTH-1:0]  data_in;
    logic [BITS_W-1:0]    bits_in;
    logic                 valid_out, ready_in, sop_out, eop_out, err_out;
    logic [OUT_WIDTH-1:0] data_out;

    modport master (
        output valid_in, data_in, sop_in, eop_in, bits_in, ready_in,
        input  ready_out, valid_out, data_out, sop_out, eop_out, err_out
    );
    modport slave (
        input  valid_in, data_in, sop_in, eop_in, bits_in, ready_in,
        output ready_out, valid_out, data_out, sop_out, eop_out, err_out
    );
endinterface

// File: rtl/packet_unpack_shift_buf.sv
// unpack_shift_buf: residue buffer plus valid-bit count for packet_unpack.
// Ports: clk, rst (async, active-high); clear_i drops the residue ahead of a load;
// load_i appends word_i (nbits_i valid bits, upper bits already zero) above the residue;
// shift_i retires one symbol; sym_o is the oldest symbol, cnt_o the residue bit count.
module unpack_shift_buf import packet_unpack_pkg::*; #(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int CW        = CNT_W,
    parameter int BW        = BUF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [IN_WIDTH-1:0]  word_i,
    input  logic [CW-1:0]        nbits_i,
    output logic [OUT_WIDTH-1:0] sym_o,
    output logic [CW-1:0]        cnt_o
);
    logic [BW-1:0] sbuf_q, sbuf_d, base;
    logic [CW-1:0] cnt_q, cnt_d, cbase;

    // Bits above cnt are kept zero, so the final short symbol comes out zero-padded.
    always_comb begin
        base   = clear_i ? '0 : sbuf_q;
        cbase  = clear_i ? '0 : cnt_q;
        sbuf_d = load_i ? base | (BW'(word_i) << cbase) : shift_i ? sbuf_q >> OUT_WIDTH : sbuf_q;
        cnt_d  = load_i ? cbase + nbits_i
               : shift_i ? (cnt_q > CW'(OUT_WIDTH) ? cnt_q - CW'(OUT_WIDTH) : '0) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbuf_q <= '0;
            cnt_q  <= '0;
        end else begin
            sbuf_q <= sbuf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sym_o = sbuf_q[OUT_WIDTH-1:0];
    assign cnt_o = cnt_q;
endmodule

// File: rtl/packet_unpack.sv
// packet_unpack: splits IN_WIDTH-bit packet words into OUT_WIDTH-bit symbols, LSB first, with framing checks.
// Ports: clk, rst (async, active-high); bus (packet_unpack_if.slave) carries the word input
// (valid_in/ready_out/data_in/sop_in/eop_in/bits_in) and symbol output
// (valid_out/ready_in/data_out/sop_out/eop_out) plus the one-cycle err_out pulse.
module packet_unpack import packet_unpack_pkg::*; #(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input logic            clk,
    input logic            rst,
    packet_unpack_if.slave bus
);
    localparam int CW = $clog2(IN_WIDTH + OUT_WIDTH);
    localparam int BW = IN_WIDTH + OUT_WIDTH - 1;

    flags_t               flg_q, flg_d;
    logic                 live_q, err_q;
    logic [CW-1:0]        cnt;
    logic [OUT_WIDTH-1:0] sym;
    logic [IN_WIDTH-1:0]  word;
    int                   nb;
    logic                 accept, xfer, load;

    always_comb begin
        nb   = valid_bits(bus.eop_in, int'(bus.bits_in), IN_WIDTH);
        word = bus.data_in & ({IN_WIDTH{1'b1}} >> (IN_WIDTH - nb));
    end

    // live_q holds ready_out low until the first clock after reset release.
    assign bus.ready_out = live_q & (cnt < CW'(OUT_WIDTH)) & ~flg_q.eop_pend;
    assign bus.valid_out = (cnt >= CW'(OUT_WIDTH)) | (flg_q.eop_pend & (cnt != '0));
    assign bus.data_out  = sym;
    assign bus.sop_out   = bus.valid_out & flg_q.sop_pend;
    assign bus.eop_out   = bus.valid_out & flg_q.eop_pend & (cnt <= CW'(OUT_WIDTH));
    assign bus.err_out   = err_q;

    assign accept = bus.valid_in & bus.ready_out;
    assign xfer   = bus.valid_out & bus.ready_in;
    // Words outside a packet are accepted but never loaded.
    assign load   = accept & (bus.sop_in | flg_q.in_pkt);

    always_comb begin
        flg_d = flg_q;
        if (load)
            flg_d = '{in_pkt: 1'b1, sop_pend: bus.sop_in | flg_q.sop_pend, eop_pend: bus.eop_in};
        else if (xfer)
            flg_d = '{in_pkt: flg_q.in_pkt & ~bus.eop_out, sop_pend: 1'b0,
                      eop_pend: flg_q.eop_pend & ~bus.eop_out};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flg_q  <= '0;
            live_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            flg_q  <= flg_d;
            live_q <= 1'b1;
            // SOP inside an open packet, or a non-SOP word outside one.
            err_q  <= accept & (bus.sop_in == flg_q.in_pkt);
        end
    end

    // A SOP word always restarts the residue, discarding any unfinished packet.
    unpack_shift_buf #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .CW       (CW),
        .BW       (BW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clear_i(accept & bus.sop_in),
        .load_i (load),
        .shift_i(xfer),
        .word_i (word),
        .nbits_i(CW'(nb)),
        .sym_o  (sym),
        .cnt_o  (cnt)
    );
endmodule

// File: tb/tb_packet_unpack.sv
// tb_packet_unpack: randomized self-checking bench for packet_unpack with a bit-queue reference model.
module tb_packet_unpack;
    localparam int IW = 32;
    localparam int OW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_unpack_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();
    packet_unpack #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int rx_base = 0;
    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];
    bit rand_ready = 1'b0;
    logic ready_fixed = 1'b1;
    bit stall_p = 1'b0;
    logic [8:0] held = '0;

    always @(posedge clk) begin
        #1 bus.ready_in = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Records every symbol transfer {eop,sop,data}, counts err pulses, checks output holds while stalled.
    always @(negedge clk) begin
        if (rst) stall_p = 1'b0;
        else begin
            if (stall_p) begin
                checks++;
                if (bus.valid_out !== 1'b1 || {bus.eop_out, bus.sop_out, bus.data_out} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b sym=%h, required valid=1 sym=%h",
                             bus.valid_out, {bus.eop_out, bus.sop_out, bus.data_out}, held);
                end
            end
            stall_p = bus.valid_out && !bus.ready_in;
            held = {bus.eop_out, bus.sop_out, bus.data_out};
            if (bus.valid_out && bus.ready_in) rx_q.push_back({bus.eop_out, bus.sop_out, bus.data_out});
            if (bus.err_out) err_seen++;
        end
    end

    // Reference: concatenate the packet's valid bits, cut into OW-bit symbols, pad the last with zeros.
    task automatic model_pkt(input logic [31:0] w[$], input logic [5:0] lb);
        logic bits[$];
        logic [6:0] s;
        int n;
        foreach (w[k]) begin
            n = (k == w.size() - 1 && lb != 0 && lb <= 32) ? int'(lb) : 32;
            for (int j = 0; j < n; j++) bits.push_back(w[k][j]);
        end
        for (int i = 0; i < bits.size(); i += OW) begin
            s = '0;
            for (int j = 0; j < OW; j++) if (i + j < bits.size()) s[j] = bits[i + j];
            exp_q.push_back({1'(i + OW >= bits.size()), 1'(i == 0), s});
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic s, input logic e, input logic [5:0] b, output bit ok);
        bus.valid_in = 1'b1;
        bus.data_in = d;
        bus.sop_in = s;
        bus.eop_in = e;
        bus.bits_in = b;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = bus.ready_out;
        end
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] w[$], input logic [5:0] lb, output bit ok);
        bit o;
        ok = 1'b1;
        foreach (w[k]) begin
            send_word(w[k], k == 0, k == w.size() - 1, lb, o);
            ok &= o;
        end
    endtask

    // Waits for n symbols past rx_base, then lets the output settle before the caller counts them.
    task automatic wait_rx(input int n);
        for (int i = 0; i < 5000 && rx_q.size() < rx_base + n; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.valid_in = 1'b0;
        bus.data_in = '0;
        bus.sop_in = 1'b0;
        bus.eop_in = 1'b0;
        bus.bits_in = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ready_out, bus.valid_out, bus.sop_out, bus.eop_out, bus.err_out, bus.data_out} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sop=%b eop=%b err=%b data=%h, required all 0",
                     bus.ready_out, bus.valid_out, bus.sop_out, bus.eop_out, bus.err_out, bus.data_out);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_release: got %b, required 1", bus.ready_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nosop;
        int e0 = err_seen;
        int vcnt = 0;
        bit ok;
        send_word($urandom, 1'b0, 1'b0, 6'd0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nosop_accept: got no accept, required accept"); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b0) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin errors++; $display("FAIL nosop_valid: got %0d valid cycles, required 0", vcnt); end
        checks++;
        if (err_seen - e0 != 1) begin errors++; $display("FAIL nosop_err: got %0d pulses, required 1", err_seen - e0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_known;
        logic [8:0] kq[$];
        bit ok;
        kq = '{9'h0EF, 9'h01B, 9'h02F, 9'h04D, 9'h108};
        rx_base = rx_q.size();
        send_word(32'h89ABCDEF, 1'b1, 1'b1, 6'd32, ok);
        @(negedge clk);
        checks++;
        if (!ok || bus.valid_out !== 1'b1 || bus.sop_out !== 1'b1) begin
            errors++;
            $display("FAIL known_latency: got ok=%b valid=%b sop=%b, required 1 1 1", ok, bus.valid_out, bus.sop_out);
        end
        wait_rx(5);
        checks++;
        if (rx_q.size() - rx_base != 5) begin errors++; $display("FAIL known_count: got %0d, required 5", rx_q.size() - rx_base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[rx_base + i] !== kq[i]) begin
                errors++;
                $display("FAIL known_sym%0d: got %h, required %h", i, rx_q[rx_base + i], kq[i]);
            end
        end
    endtask

    task automatic test_short;
        logic [31:0] w[$];
        bit ok;
        rx_base = rx_q.size();
        send_word(32'hFFFFFFFF, 1'b1, 1'b1, 6'd8, ok);
        for (int i = 0; i < 50 && rx_q.size() < rx_base + 2; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL short_ready: got %b, required 1", bus.ready_out); end
        checks++;
        if (rx_q.size() - rx_base != 2 || rx_q[rx_base] !== 9'h0FF || rx_q[rx_base + 1] !== 9'h101) begin
            errors++;
            $display("FAIL short_syms: got n=%0d %h %h, required n=2 0ff 101", rx_q.size() - rx_base,
                     rx_q[rx_base], rx_q[rx_base + 1]);
        end
        @(posedge clk);
        #1;
        // bits_in of 0 and above IN_WIDTH both mean a full word.
        foreach (w[k]) w.delete(k);
        w.push_back($urandom);
        exp_q.delete();
        rx_base = rx_q.size();
        model_pkt(w, 6'd0);
        send_pkt(w, 6'd0, ok);
        w[0] = $urandom;
        model_pkt(w, 6'd45);
        send_pkt(w, 6'd45, ok);
        wait_rx(exp_q.size());
        checks++;
        if (rx_q.size() - rx_base != exp_q.size()) begin
            errors++;
            $display("FAIL clamp_count: got %0d, required %0d", rx_q.size() - rx_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[rx_base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL clamp_sym%0d: got %h, required %h", i, rx_q[rx_base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] w[$];
        bit ok;
        bit all_ok = 1'b1;
        int e0 = err_seen;
        rand_ready = 1'b1;
        exp_q.delete();
        rx_base = rx_q.size();
        w.push_back($urandom);
        w.push_back($urandom);
        model_pkt(w, 6'd32);
        send_pkt(w, 6'd32, ok);
        wait_rx(10);
        checks++;
        if (rx_q.size() - rx_base != 10) begin errors++; $display("FAIL stall_two_word_count: got %0d, required 10", rx_q.size() - rx_base); end
        for (int p = 0; p < 12; p++) begin
            logic [5:0] lb = 6'($urandom_range(0, 63));
            w.delete();
            for (int j = 0; j < $urandom_range(1, 4); j++) w.push_back($urandom);
            model_pkt(w, lb);
            send_pkt(w, lb, ok);
            all_ok &= ok;
        end
        wait_rx(exp_q.size());
        rand_ready = 1'b0;
        checks++;
        if (!all_ok || rx_q.size() - rx_base != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count: got ok=%b n=%0d, required ok=1 n=%0d", all_ok, rx_q.size() - rx_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[rx_base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_sym%0d: got %h, required %h", i, rx_q[rx_base + i], exp_q[i]);
            end
        end
        checks++;
        if (err_seen != e0) begin errors++; $display("FAIL stall_err: got %0d pulses, required 0", err_seen - e0); end
    endtask

    task automatic test_sop_err;
        logic [31:0] a[$];
        logic [31:0] b[$];
        bit ok1, ok2;
        int e0 = err_seen;
        a.push_back($urandom);
        b.push_back($urandom);
        exp_q.delete();
        rx_base = rx_q.size();
        // Old packet: its four full symbols go out, the 4-bit residue is lost and no eop is seen.
        model_pkt(a, 6'd32);
        void'(exp_q.pop_back());
        model_pkt(b, 6'd32);
        send_word(a[0], 1'b1, 1'b0, 6'd32, ok1);
        send_word(b[0], 1'b1, 1'b1, 6'd32, ok2);
        wait_rx(exp_q.size());
        checks++;
        if (!(ok1 && ok2) || rx_q.size() - rx_base != exp_q.size()) begin
            errors++;
            $display("FAIL soperr_count: got n=%0d, required n=%0d", rx_q.size() - rx_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[rx_base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL soperr_sym%0d: got %h, required %h", i, rx_q[rx_base + i], exp_q[i]);
            end
        end
        checks++;
        if (err_seen - e0 != 1) begin errors++; $display("FAIL soperr_err: got %0d pulses, required 1", err_seen - e0); end
    endtask

    task automatic test_async_reset;
        logic [31:0] w[$];
        bit ok;
        ready_fixed = 1'b0;
        rx_base = rx_q.size();
        send_word($urandom, 1'b1, 1'b1, 6'd32, ok);
        @(negedge clk);
        checks++;
        if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b, required 1", bus.valid_out); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.eop_out !== 1'b0 || bus.ready_out !== 1'b0) begin
            errors++;
            $display("FAIL areset_outputs: got vld=%b eop=%b rdy=%b, required 0 0 0", bus.valid_out, bus.eop_out, bus.ready_out);
        end
        ready_fixed = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        w.push_back($urandom);
        w.push_back($urandom);
        model_pkt(w, 6'd19);
        send_pkt(w, 6'd19, ok);
        wait_rx(exp_q.size());
        checks++;
        if (!ok || rx_q.size() - rx_base != exp_q.size()) begin
            errors++;
            $display("FAIL areset_count: got n=%0d, required n=%0d", rx_q.size() - rx_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[rx_base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL areset_sym%0d: got %h, required %h", i, rx_q[rx_base + i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nosop();
        test_known();
        test_short();
        test_stall();
        test_sop_err();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
